// File: rtl/gate_sweep_if.sv
// Handshake/result bundle between a sweep checker and whoever starts it
// and supplies the gate-under-test output.
interface gate_sweep_if;
    logic       start;
    logic       gate_c;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] err_mask;
    logic [1:0] vec_idx;

    // Side that requests sweeps and closes the loop through the gate.
    modport master (
        output start,
        output gate_c,
        input  gate_a,
        input  gate_b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  err_mask,
        input  vec_idx
    );

    // The checker itself.
    modport slave (
        input  start,
        input  gate_c,
        output gate_a,
        output gate_b,
        output busy,
        output done,
        output pass,
        output err_count,
        output err_mask,
        output vec_idx
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep of a 2-input combinational gate: drives the four input
// vectors in order, holds each for SETTLE_CYCLES+1 cycles, samples gate_c on
// the last edge of each hold and compares it with the EXPECTED truth table.
// All outputs are flops, so nothing here is combinational from gate_c/start.
module gate_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b1000
) (
    input  logic         clk,
    input  logic         rst_n,
    gate_sweep_if.slave  bus
);

    localparam int unsigned           CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when the sampled gate output disagrees with the table entry.
    function automatic logic vec_mismatch(input logic [3:0] table_bits,
                                          input logic [1:0] idx,
                                          input logic       sample);
        return sample != table_bits[idx];
    endfunction

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [1:0]       vec_idx_q,   vec_idx_d;
    logic             gate_a_q,    gate_a_d;
    logic             gate_b_q,    gate_b_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             pass_q,      pass_d;
    logic [2:0]       err_count_q, err_count_d;
    logic [3:0]       err_mask_q,  err_mask_d;
    logic             mis_s;

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_idx_d   = vec_idx_q;
        gate_a_d    = gate_a_q;
        gate_b_d    = gate_b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;
        mis_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                busy_d   = 1'b0;
                if (bus.start) begin
                    // Vector 0 is {0,0}, so gate inputs stay low on entry.
                    state_d     = ST_RUN;
                    busy_d      = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                    vec_idx_d   = 2'd0;
                    err_count_d = 3'd0;
                    err_mask_d  = 4'b0000;
                    pass_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                busy_d = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    // Sample edge for the current vector.
                    mis_s = vec_mismatch(EXPECTED, vec_idx_q, bus.gate_c);
                    if (mis_s) begin
                        err_mask_d = err_mask_q | (4'b0001 << vec_idx_q);
                        if (err_count_q != 3'd4) begin
                            err_count_d = err_count_q + 3'd1;
                        end else begin
                            err_count_d = err_count_q;
                        end
                    end else begin
                        err_mask_d  = err_mask_q;
                        err_count_d = err_count_q;
                    end
                    cnt_d = {CNT_W{1'b0}};
                    if (vec_idx_q == 2'd3) begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        gate_a_d = 1'b0;
                        gate_b_d = 1'b0;
                        pass_d   = (err_count_d == 3'd0);
                    end else begin
                        vec_idx_d = vec_idx_q + 2'd1;
                        gate_a_d  = vec_idx_d[1];
                        gate_b_d  = vec_idx_d[0];
                    end
                end
            end

            ST_DONE: begin
                // Results are final here; return to IDLE after one cycle.
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any sweep and clears results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            vec_idx_q   <= 2'd0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 3'd0;
            err_mask_q  <= 4'b0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_idx_q   <= vec_idx_d;
            gate_a_q    <= gate_a_d;
            gate_b_q    <= gate_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
        end
    end

    assign bus.gate_a    = gate_a_q;
    assign bus.gate_b    = gate_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.err_mask  = err_mask_q;
    assign bus.vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: stimulus pushes the hand-computed result of each sweep,
// per-DUT monitors pop and compare whenever done is seen.
module tb_gate_sweep_checker;

    localparam int M_AND = 0, M_ST0 = 1, M_OR = 2, M_NAND = 3, M_XOR = 4;

    typedef struct {
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       pass;
        int         dcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   mode0 = M_AND;
    int   mode1 = M_XOR;
    exp_t q0[$];
    exp_t q1[$];
    logic [1:0] seq0[$];

    gate_sweep_if if0 ();
    gate_sweep_if if1 ();

    gate_sweep_checker #(.SETTLE_CYCLES(2), .EXPECTED(4'b1000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    gate_sweep_checker #(.SETTLE_CYCLES(1), .EXPECTED(4'b0110)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            M_AND:   return a & b;
            M_ST0:   return 1'b0;
            M_OR:    return a | b;
            M_NAND:  return ~(a & b);
            M_XOR:   return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    assign if0.gate_c = gate_model(mode0, if0.gate_a, if0.gate_b);
    assign if1.gate_c = gate_model(mode1, if1.gate_a, if1.gate_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor for dut0: compare results and done timing against the scoreboard.
    always @(negedge clk) begin
        if (if0.busy) seq0.push_back({if0.gate_a, if0.gate_b});
        if (rst_n && if0.done) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0_done_cycle", cyc, e.dcyc);
                check("dut0_err_mask", {28'd0, if0.err_mask}, {28'd0, e.mask});
                check("dut0_err_count", {29'd0, if0.err_count}, {29'd0, e.cnt});
                check("dut0_pass", {31'd0, if0.pass}, {31'd0, e.pass});
                check("dut0_busy_at_done", {31'd0, if0.busy}, 32'd0);
            end
        end
    end

    // Monitor for dut1.
    always @(negedge clk) begin
        if (rst_n && if1.done) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_done_cycle", cyc, e.dcyc);
                check("dut1_err_mask", {28'd0, if1.err_mask}, {28'd0, e.mask});
                check("dut1_err_count", {29'd0, if1.err_count}, {29'd0, e.cnt});
                check("dut1_pass", {31'd0, if1.pass}, {31'd0, e.pass});
            end
        end
    end

    // Called at a negedge: start is accepted on the next posedge (cyc+1).
    task automatic push_exp(input int d, input logic [3:0] m, input logic [2:0] c,
                            input logic p, input int dc);
        exp_t e;
        e.mask = m; e.cnt = c; e.pass = p; e.dcyc = dc;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic issue(input int d, input logic [3:0] m, input logic [2:0] c, input logic p);
        if (d == 0) begin
            push_exp(0, m, c, p, cyc + 1 + 12);
            if0.start = 1'b1;
            @(negedge clk);
            if0.start = 1'b0;
        end else begin
            push_exp(1, m, c, p, cyc + 1 + 8);
            if1.start = 1'b1;
            @(negedge clk);
            if1.start = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            check({name, "_timeout"}, q0.size() + q1.size(), 32'd0);
            q0.delete();
            q1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of both instances.
        check("rst_dut0", {if0.gate_a, if0.gate_b, if0.busy, if0.done, if0.pass,
                           if0.err_count, if0.err_mask, if0.vec_idx}, 32'd0);
        check("rst_dut1", {if1.gate_a, if1.gate_b, if1.busy, if1.done, if1.pass,
                           if1.err_count, if1.err_mask, if1.vec_idx}, 32'd0);

        // AND gate, defaults: pass, plus gate input sequence.
        mode0 = M_AND;
        seq0.delete();
        issue(0, 4'b0000, 3'd0, 1'b1);
        drain("and");
        check("seq_len", seq0.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < seq0.size()) check("seq_ab", {30'd0, seq0[i]}, i / 3);
        end

        // Stuck-at-0, OR, NAND against the AND table.
        mode0 = M_ST0;
        issue(0, 4'b1000, 3'd1, 1'b0);
        drain("stuck0");
        check("idle_hold_mask", {28'd0, if0.err_mask}, 32'h8);
        mode0 = M_OR;
        issue(0, 4'b0110, 3'd2, 1'b0);
        drain("or");
        mode0 = M_NAND;
        issue(0, 4'b1111, 3'd4, 1'b0);
        drain("nand");

        // XOR against its own table, SETTLE_CYCLES = 1.
        mode1 = M_XOR;
        issue(1, 4'b0000, 3'd0, 1'b1);
        drain("xor");

        // Reset mid-sweep at vec_idx = 2 with errors already accumulated.
        mode0 = M_NAND;
        issue(0, 4'b1111, 3'd4, 1'b0);
        begin
            int n;
            n = 0;
            while (if0.vec_idx != 2'd2 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("reach_vec2", {30'd0, if0.vec_idx}, 32'd2);
        end
        check("pre_rst_errs", {29'd0, if0.err_count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", {if0.gate_a, if0.gate_b, if0.busy, if0.done, if0.pass,
                                 if0.err_count, if0.err_mask, if0.vec_idx}, 32'd0);
        void'(q0.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Full sweep after reset.
        mode0 = M_AND;
        issue(0, 4'b0000, 3'd0, 1'b1);
        drain("after_rst");

        // start pulsed while busy is ignored.
        mode0 = M_OR;
        issue(0, 4'b0110, 3'd2, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_mid", {31'd0, if0.busy}, 32'd1);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        drain("busy_start");

        // start held across done: back-to-back sweeps, results cleared on restart.
        mode0 = M_NAND;
        begin
            int n0;
            n0 = cyc;
            push_exp(0, 4'b1111, 3'd4, 1'b0, n0 + 13);
            push_exp(0, 4'b1111, 3'd4, 1'b0, n0 + 27);
            if0.start = 1'b1;
            while (cyc < n0 + 15) @(negedge clk);
            check("restart_busy", {31'd0, if0.busy}, 32'd1);
            check("restart_cleared", {if0.pass, if0.err_count, if0.err_mask}, 32'd0);
            if0.start = 1'b0;
        end
        drain("held");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
